// File: rtl/img_downsample.sv
// 2x2 box-filter downsampler: streams a WIDTH x HEIGHT image out of a 2-cycle-latency BRAM in
// block order and writes the truncated mean of each 2x2 block as a half-resolution raster.
module img_downsample #(
  parameter int unsigned BIT_DEPTH = 8,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned HEIGHT    = 64
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                start_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]     ext_read_addr,
  output logic                                ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]                ext_pixel_in,
  output logic [$clog2(WIDTH*HEIGHT/4)-1:0]   ext_write_addr,
  output logic                                ext_write_valid,
  output logic [BIT_DEPTH-1:0]                ext_pixel_out,
  output logic                                busy_out,
  output logic                                done_out
);

  localparam int unsigned NPix = WIDTH * HEIGHT;
  localparam int unsigned AW   = $clog2(NPix);
  localparam int unsigned OW   = $clog2(NPix / 4);
  localparam int unsigned AccW = BIT_DEPTH + 2;
  localparam int unsigned OutW = WIDTH / 2;
  localparam int unsigned OutH = HEIGHT / 2;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             phase_q, phase_d;
  logic [1:0]             drain_q, drain_d;
  logic [AW-1:0]          ox_q, ox_d, oy_q, oy_d;
  logic [AW-1:0]          rd_addr_q, rd_addr_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   busy_q, busy_d, done_q, done_d;
  // Read tags delayed to line up with the BRAM's 2-cycle output.
  logic                   p1_v_q, p1_v_d, p2_v_q, p2_v_d;
  logic [1:0]             p1_ph_q, p1_ph_d, p2_ph_q, p2_ph_d;
  logic [OW-1:0]          p1_wa_q, p1_wa_d, p2_wa_q, p2_wa_d;
  logic [AccW-1:0]        acc_q, acc_d, sum;
  logic [OW-1:0]          wr_addr_q, wr_addr_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [BIT_DEPTH-1:0]   pix_out_q, pix_out_d;
  logic [31:0]            row_w, col_w;
  logic                   is_last;

  assign is_last = (phase_q == 2'd3) && (ox_q == AW'(OutW - 1)) && (oy_q == AW'(OutH - 1));

  // Control FSM and read-address generator (block order: TL, TR, BL, BR).
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    drain_d    = drain_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = rd_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    p1_v_d     = 1'b0;
    p1_ph_d    = phase_q;
    p1_wa_d    = OW'(32'(oy_q) * OutW + 32'(ox_q));
    row_w      = '0;
    col_w      = '0;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d    = StRead;
          phase_d    = 2'd0;
          ox_d       = '0;
          oy_d       = '0;
          rd_addr_d  = '0;
          rd_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      StRead: begin
        p1_v_d = 1'b1;
        if (is_last) begin
          state_d = StDrain;
          drain_d = 2'd0;
        end else begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (ox_q == AW'(OutW - 1)) begin
              ox_d = '0;
              oy_d = oy_q + AW'(1);
            end else begin
              ox_d = ox_q + AW'(1);
            end
          end
          row_w     = (32'(oy_d) << 1) + 32'(phase_d[1]);
          col_w     = (32'(ox_d) << 1) + 32'(phase_d[0]);
          rd_addr_d = AW'(row_w * WIDTH + col_w);
        end
      end
      StDrain: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          state_d    = StDone;
          rd_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Accumulate samples as they return; emit the mean on a block's fourth sample.
  always_comb begin
    p2_v_d     = p1_v_q;
    p2_ph_d    = p1_ph_q;
    p2_wa_d    = p1_wa_q;
    sum        = acc_q + AccW'(ext_pixel_in);
    acc_d      = acc_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    pix_out_d  = pix_out_q;
    if (p2_v_q) begin
      acc_d = (p2_ph_q == 2'd0) ? AccW'(ext_pixel_in) : sum;
      if (p2_ph_q == 2'd3) begin
        wr_valid_d = 1'b1;
        wr_addr_d  = p2_wa_q;
        pix_out_d  = sum[AccW-1:2];
      end
    end
  end

  // State registers; reset aborts the frame and flushes the read pipeline.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      drain_q    <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      p1_v_q     <= 1'b0;
      p1_ph_q    <= '0;
      p1_wa_q    <= '0;
      p2_v_q     <= 1'b0;
      p2_ph_q    <= '0;
      p2_wa_q    <= '0;
      acc_q      <= '0;
      wr_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      pix_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      drain_q    <= drain_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      p1_v_q     <= p1_v_d;
      p1_ph_q    <= p1_ph_d;
      p1_wa_q    <= p1_wa_d;
      p2_v_q     <= p2_v_d;
      p2_ph_q    <= p2_ph_d;
      p2_wa_q    <= p2_wa_d;
      acc_q      <= acc_d;
      wr_addr_q  <= wr_addr_d;
      wr_valid_q <= wr_valid_d;
      pix_out_q  <= pix_out_d;
    end
  end

  assign ext_read_addr       = rd_addr_q;
  assign ext_read_addr_valid = rd_valid_q;
  assign ext_write_addr      = wr_addr_q;
  assign ext_write_valid     = wr_valid_q;
  assign ext_pixel_out       = pix_out_q;
  assign busy_out            = busy_q;
  assign done_out            = done_q;

endmodule
